gp_dense_scheduler: RTL and testbench

- Wrapper-side controller for the AXI-Stream buffer interface.
- On a start pulse it walks the input buffer and an external weight ROM and runs a single-lane pipelined signed fixed-point MAC. It computes OUT_DATA_NUM dot products of length IN_DATA_NUM and writes each result into the output buffer.
- It pulses done when all results are written, handing the output buffer back for master-side streaming.

---
 rtl/gp_dense_scheduler.sv | 137 +++++++++++++
 tb/tb_gp_dense_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gp_dense_scheduler.sv
// Dense-layer scheduler: walks the input buffer and weight ROM, runs a pipelined signed fixed-point MAC
// and writes saturated results to the output buffer. Define GP_DENSE_SCHEDULER_RELU_EN to clamp negative results to 0.
module gp_dense_scheduler #(
   parameter  int DATA_WIDTH   = 32,
   parameter  int IN_DATA_NUM  = 8,
   parameter  int OUT_DATA_NUM = 4,
   parameter  int FRAC_BITS    = 8,
   localparam int KW    = (IN_DATA_NUM > 1) ? $clog2(IN_DATA_NUM) : 1,
   localparam int OW    = (OUT_DATA_NUM > 1) ? $clog2(OUT_DATA_NUM) : 1,
   localparam int WW    = (IN_DATA_NUM * OUT_DATA_NUM > 1) ? $clog2(IN_DATA_NUM * OUT_DATA_NUM) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  done,
   output logic                  busy,
   output logic [KW-1:0]         bufferIn_adr,
   input  logic [DATA_WIDTH-1:0] bufferIn_data,
   output logic [WW-1:0]         w_adr,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic [OW-1:0]         bufferOut_adr,
   output logic [DATA_WIDTH-1:0] bufferOut_data,
   output logic                  bufferOut_wr
);

   localparam int PW    = 2 * DATA_WIDTH;
   localparam int ACC_W = 2 * DATA_WIDTH - FRAC_BITS + $clog2(IN_DATA_NUM);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DRAIN1 = 3'd2,
      DRAIN2 = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t state, stateNext;

   logic [KW-1:0]            k;
   logic [OW-1:0]            o;
   logic                     pValid;
   logic signed [PW-1:0]     prodReg;
   logic signed [ACC_W-1:0]  acc;
   logic signed [PW-1:0]     inExt, wExt;
   logic [DATA_WIDTH-1:0]    satVal, wrVal;

   wire lastK = (k == KW'(IN_DATA_NUM - 1));
   wire lastO = (o == OW'(OUT_DATA_NUM - 1));

   // Operands are sign-extended explicitly so the product keeps full precision.
   assign inExt = {{DATA_WIDTH{bufferIn_data[DATA_WIDTH-1]}}, bufferIn_data};
   assign wExt  = {{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         o       <= '0;
         pValid  <= 1'b0;
         prodReg <= '0;
         acc     <= '0;
      end else begin
         state   <= stateNext;
         pValid  <= (state == FETCH);
         prodReg <= inExt * wExt;
         if (pValid)
            acc <= acc + ACC_W'(prodReg >>> FRAC_BITS);
         case (state)
            IDLE: if (start) begin
               k   <= '0;
               o   <= '0;
               acc <= '0;
            end
            FETCH: if (!lastK) k <= k + 1'b1;
            WRITE: begin
               acc <= '0;
               k   <= '0;
               o   <= lastO ? '0 : o + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = FETCH;
         FETCH:   if (lastK) stateNext = DRAIN1;
         DRAIN1:  stateNext = DRAIN2;
         DRAIN2:  stateNext = WRITE;
         WRITE:   stateNext = lastO ? DONE : FETCH;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      satVal = acc[DATA_WIDTH-1:0];
      if (acc > SAT_MAX)
         satVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc < SAT_MIN)
         satVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef GP_DENSE_SCHEDULER_RELU_EN
      wrVal = satVal[DATA_WIDTH-1] ? '0 : satVal;
`else
      wrVal = satVal;
`endif
   end

   always_comb begin
      done           = 1'b0;
      busy           = (state != IDLE);
      bufferIn_adr   = '0;
      w_adr          = '0;
      bufferOut_adr  = '0;
      bufferOut_data = '0;
      bufferOut_wr   = 1'b0;
      case (state)
         FETCH: begin
            bufferIn_adr = k;
            w_adr        = WW'(o) * WW'(IN_DATA_NUM) + WW'(k);
         end
         WRITE: begin
            bufferOut_wr   = 1'b1;
            bufferOut_adr  = o;
            bufferOut_data = wrVal;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gp_dense_scheduler.sv
// Directed bench for gp_dense_scheduler: table of input/weight patterns with hand-computed results,
// plus sequences for start re-pulsing, mid-run reset and back-to-back runs.
module tb_gp_dense_scheduler;

   localparam int DW = 32;
   localparam int NI = 8;
   localparam int NO = 4;
   localparam int RUN_LAT = 45;
   localparam int WR_GAP  = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          done, busy;
   logic [2:0]    bufferIn_adr;
   logic [DW-1:0] bufferIn_data;
   logic [4:0]    w_adr;
   logic [DW-1:0] w_data;
   logic [1:0]    bufferOut_adr;
   logic [DW-1:0] bufferOut_data;
   logic          bufferOut_wr;

   logic [DW-1:0] inMem [NI];
   logic [DW-1:0] wMem  [NI*NO];

   gp_dense_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
      .bufferIn_adr(bufferIn_adr), .bufferIn_data(bufferIn_data),
      .w_adr(w_adr), .w_data(w_data),
      .bufferOut_adr(bufferOut_adr), .bufferOut_data(bufferOut_data),
      .bufferOut_wr(bufferOut_wr)
   );

   assign bufferIn_data = inMem[bufferIn_adr];
   assign w_data        = wMem[w_adr];

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: log writes and done pulses away from the active edge
   logic [1:0]    wrAdr_q[$];
   logic [DW-1:0] wrData_q[$];
   int            wrCyc_q[$];
   int            doneCyc_q[$];
   always @(negedge clk) begin
      if (bufferOut_wr) begin
         wrAdr_q.push_back(bufferOut_adr);
         wrData_q.push_back(bufferOut_data);
         wrCyc_q.push_back(cyc);
      end
      if (done) doneCyc_q.push_back(cyc);
   end

   // scoreboard
   logic [DW-1:0] exp_q[$];
   int nCompared = 0;
   int nMismatch = 0;
   int startCyc  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef GP_DENSE_SCHEDULER_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   typedef struct {
      string         tag;
      logic [DW-1:0] in0, inStep, w0, wStep, exp0, expStep;
   } vec_t;
   vec_t vecs[6];

   task automatic loadVec(input vec_t v);
      for (int kk = 0; kk < NI; kk++) inMem[kk] = v.in0 + v.inStep * kk;
      for (int oo = 0; oo < NO; oo++)
         for (int kk = 0; kk < NI; kk++) wMem[oo*NI+kk] = v.w0 + v.wStep * oo;
   endtask

   task automatic clearLogs();
      wrAdr_q.delete(); wrData_q.delete(); wrCyc_q.delete(); doneCyc_q.delete(); exp_q.delete();
   endtask

   task automatic startPulse();
      @(negedge clk);
      start = 1'b1;
      startCyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic gotoRel(input int r);
      while (cyc - startCyc < r) @(negedge clk);
   endtask

   task automatic waitDone(input string tag, input int n);
      for (int i = 0; i < 400 && doneCyc_q.size() < n; i++) begin
         @(negedge clk);
         #1;
      end
      check({tag, "_done_seen"}, doneCyc_q.size() >= n, 1);
      repeat (20) @(negedge clk);
   endtask

   task automatic checkRuns(input string tag, input vec_t v, input int nRuns);
      int n;
      for (int r = 0; r < nRuns; r++)
         for (int oo = 0; oo < NO; oo++) exp_q.push_back(relu(v.exp0 + v.expStep * oo));
      check({tag, "_wr_count"}, wrData_q.size(), NO * nRuns);
      check({tag, "_done_count"}, doneCyc_q.size(), nRuns);
      n = (wrData_q.size() < NO * nRuns) ? wrData_q.size() : NO * nRuns;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data%0d", tag, i), wrData_q[i], exp_q.pop_front());
         check($sformatf("%s_adr%0d", tag, i), wrAdr_q[i], i % NO);
         check($sformatf("%s_wrcyc%0d", tag, i), wrCyc_q[i] - startCyc,
               WR_GAP * (i % NO + 1) + (RUN_LAT + 1) * (i / NO));
      end
      for (int r = 0; r < nRuns && r < doneCyc_q.size(); r++)
         check($sformatf("%s_done_lat%0d", tag, r), doneCyc_q[r] - startCyc,
               RUN_LAT + (RUN_LAT + 1) * r);
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_in_adr"}, bufferIn_adr, 0);
      check({tag, "_w_adr"}, w_adr, 0);
      check({tag, "_out_adr"}, bufferOut_adr, 0);
      check({tag, "_out_data"}, bufferOut_data, 0);
      check({tag, "_out_wr"}, bufferOut_wr, 0);
   endtask

   initial begin
      vecs[0] = '{"unity",     32'd256,        32'd0,   32'd256,        32'd0,   32'd2048,       32'd0};
      vecs[1] = '{"per_out",   32'd256,        32'd256, 32'd0,          32'd256, 32'd0,          32'd9216};
      vecs[2] = '{"sat_pos",   32'h7FFF_FFFF,  32'd0,   32'h7FFF_FFFF,  32'd0,   32'h7FFF_FFFF,  32'd0};
      vecs[3] = '{"sat_neg",   32'h8000_0000,  32'd0,   32'h7FFF_FFFF,  32'd0,   32'h8000_0000,  32'd0};
      vecs[4] = '{"neg_frac",  32'hFFFF_FE00,  32'd0,   32'd256,        32'd256, 32'hFFFF_F000,  32'hFFFF_F000};
      vecs[5] = '{"shift_flr", 32'hFFFF_FFFF,  32'd0,   32'd1,          32'd0,   32'hFFFF_FFF8,  32'd0};
      loadVec(vecs[0]);

      // reset state
      repeat (3) @(negedge clk);
      #1;
      checkIdleOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven single runs
      for (int i = 0; i < 6; i++) begin
         loadVec(vecs[i]);
         clearLogs();
         startPulse();
         waitDone(vecs[i].tag, 1);
         checkRuns(vecs[i].tag, vecs[i], 1);
      end

      // start re-pulsed mid-run is ignored
      loadVec(vecs[1]);
      clearLogs();
      startPulse();
      gotoRel(5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      gotoRel(44);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("repulse", 1);
      repeat (40) @(negedge clk);
      checkRuns("repulse", vecs[1], 1);
      check("repulse_idle_busy", busy, 0);

      // asynchronous reset during the second output's fetch
      loadVec(vecs[1]);
      clearLogs();
      startPulse();
      gotoRel(WR_GAP + 2);
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("midrst");
      clearLogs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("midrst_no_writes", wrData_q.size(), 0);
      check("midrst_no_done", doneCyc_q.size(), 0);
      startPulse();
      waitDone("after_rst", 1);
      checkRuns("after_rst", vecs[1], 1);

      // back-to-back with start held high
      loadVec(vecs[4]);
      clearLogs();
      @(negedge clk);
      start = 1'b1;
      startCyc = cyc;
      for (int i = 0; i < 400 && doneCyc_q.size() < 2; i++) begin
         @(negedge clk);
         #1;
      end
      start = 1'b0;
      check("b2b_done_seen", doneCyc_q.size() >= 2, 1);
      repeat (60) @(negedge clk);
      checkRuns("b2b", vecs[4], 2);
      check("b2b_idle_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit 200000");
      $fatal(1, "timeout");
   end

endmodule
